// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice:
// fetch state enum, width/step defaults, timeout counter sizing.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetch_state_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_PC_STEP    = 4;
  localparam int DEF_TIMEOUT    = 255;

  // The counter only has to hold 0 .. n-1; the abort
  // fires on the miss that would make it reach n.
  function automatic int tmo_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_TMO_W = tmo_width(DEF_TIMEOUT);

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: PC/control in, instruction memory, decode and PC write-back.
// master = fetch unit, slave = PC register/memory/decode side.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH
);
  logic [AW-1:0] Pc_in;
  logic          Fetch_start;
  logic          Flush;
  logic [AW-1:0] Mem_addr;
  logic          Mem_req;
  logic          Mem_ready;
  logic [AW-1:0] Mem_data;
  logic [AW-1:0] Instr_out;
  logic [AW-1:0] Instr_pc;
  logic          Instr_valid;
  logic          Instr_ack;
  logic [AW-1:0] Pc_next;
  logic          Pc_write;
  logic          Busy;
  logic          Fetch_error;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          Misaligned;
`endif

  modport master (
    input  Pc_in, Fetch_start, Flush,
    input  Mem_ready, Mem_data, Instr_ack,
`ifdef FETCH_ALIGN_CHECK_EN
    output Misaligned,
`endif
    output Mem_addr, Mem_req,
    output Instr_out, Instr_pc, Instr_valid,
    output Pc_next, Pc_write,
    output Busy, Fetch_error
  );

  modport slave (
    output Pc_in, Fetch_start, Flush,
    output Mem_ready, Mem_data, Instr_ack,
`ifdef FETCH_ALIGN_CHECK_EN
    input  Misaligned,
`endif
    input  Mem_addr, Mem_req,
    input  Instr_out, Instr_pc, Instr_valid,
    input  Pc_next, Pc_write,
    input  Busy, Fetch_error
  );

endinterface

// File: rtl/instruction_fetch_unit_timeout.sv
// fetch_timeout_counter: counts enabled cycles, clr resets it.
// Ports: clk, rst, clr, en in; tc out (en on the LIMIT-th count).
module fetch_timeout_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT,
  parameter int W     = tmo_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= cnt_q + W'(1);
  end

  // LIMIT of zero means the watchdog never fires.
  generate
    if (LIMIT == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      assign tc = en && (cnt_q == W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads one word at PC, holds it for decode, writes PC+step.
// Ports: Clock_in, Signal_reset (async high), bus (master modport).
// Optional FETCH_ALIGN_CHECK_EN adds a one-cycle Misaligned pulse.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int PC_STEP        = DEF_PC_STEP,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic Clock_in,
  input  logic Signal_reset,
  instruction_fetch_unit_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [ADDR_WIDTH-1:0] pcn_q, pcn_d;
  logic                  pcw_q, pcw_d;
  logic                  err_q, err_d;
  logic                  go;
  logic                  tmo;
  logic                  tmo_clr;
  logic                  tmo_en;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                  mis_q, mis_d;
`endif

  assign tmo_clr = bus.Flush || (state_q != REQ);
  assign tmo_en  = !bus.Flush && (state_q == REQ)
                && !bus.Mem_ready;

  fetch_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk (Clock_in),
    .rst (Signal_reset),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pcn_d   = pcn_q;
    pcw_d   = 1'b0;
    err_d   = err_q;
    go      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d   = 1'b0;
`endif
    if (bus.Flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: go = bus.Fetch_start;
        REQ: begin
          if (bus.Mem_ready) begin
            instr_d = bus.Mem_data;
            ipc_d   = pc_q;
            pcn_d   = pc_q + ADDR_WIDTH'(PC_STEP);
            pcw_d   = 1'b1;
            state_d = HOLD;
          end else if (tmo) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (bus.Instr_ack) begin
            state_d = IDLE;
            go      = bus.Fetch_start;
          end
        end
        default: state_d = IDLE;
      endcase
      // Accepted start, from IDLE or back-to-back out of HOLD.
      if (go) begin
        err_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (|bus.Pc_in[1:0]) begin
          mis_d   = 1'b1;
          state_d = IDLE;
        end else
`endif
        begin
          pc_d    = bus.Pc_in;
          state_d = REQ;
        end
      end
    end
  end

  always_ff @(posedge Clock_in or posedge Signal_reset) begin
    if (Signal_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      pcn_q   <= '0;
      pcw_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pcn_q   <= pcn_d;
      pcw_q   <= pcw_d;
      err_q   <= err_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus.Mem_req     = (state_q == REQ);
  assign bus.Mem_addr    = pc_q;
  assign bus.Instr_valid = (state_q == HOLD);
  assign bus.Instr_out   = instr_q;
  assign bus.Instr_pc    = ipc_q;
  assign bus.Pc_next     = pcn_q;
  assign bus.Pc_write    = pcw_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.Fetch_error = err_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.Misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (TIMEOUT_CYCLES=4).
// Prints one summary line; mismatches print FAIL lines.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .Clock_in     (clk),
    .Signal_reset (rst),
    .bus          (bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Pc_in       = '0;
    bus.Fetch_start = 1'b0;
    bus.Flush       = 1'b0;
    bus.Mem_ready   = 1'b0;
    bus.Mem_data    = '0;
    bus.Instr_ack   = 1'b0;
    #12;
    check("rst_req",   32'(bus.Mem_req), 32'd0);
    check("rst_busy",  32'(bus.Busy), 32'd0);
    check("rst_valid", 32'(bus.Instr_valid), 32'd0);
    check("rst_pcw",   32'(bus.Pc_write), 32'd0);
    check("rst_err",   32'(bus.Fetch_error), 32'd0);
    check("rst_pcn",   bus.Pc_next, 32'h0);
    rst = 1'b0;
    tick();

    // Mem_ready in IDLE is ignored
    bus.Mem_ready = 1'b1;
    bus.Mem_data  = 32'h1234_5678;
    tick();
    check("idle_rdy_valid", 32'(bus.Instr_valid), 32'd0);
    check("idle_rdy_pcw",   32'(bus.Pc_write), 32'd0);
    bus.Mem_ready = 1'b0;

    // Flush wins over Fetch_start
    bus.Pc_in       = 32'h0000_0080;
    bus.Fetch_start = 1'b1;
    bus.Flush       = 1'b1;
    tick();
    check("flush_start_busy", 32'(bus.Busy), 32'd0);
    check("flush_start_req",  32'(bus.Mem_req), 32'd0);
    bus.Fetch_start = 1'b0;
    bus.Flush       = 1'b0;

    // Basic fetch, ready after 3 REQ cycles
    bus.Pc_in       = 32'h0000_0100;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    check("f1_req",  32'(bus.Mem_req), 32'd1);
    check("f1_addr", bus.Mem_addr, 32'h100);
    check("f1_busy", 32'(bus.Busy), 32'd1);
    tick();
    tick();
    check("f1_req_hold", 32'(bus.Mem_req), 32'd1);
    bus.Mem_ready = 1'b1;
    bus.Mem_data  = 32'h8C22_0004;
    tick();
    bus.Mem_ready = 1'b0;
    check("f1_valid", 32'(bus.Instr_valid), 32'd1);
    check("f1_instr", bus.Instr_out, 32'h8C22_0004);
    check("f1_ipc",   bus.Instr_pc, 32'h100);
    check("f1_pcw",   32'(bus.Pc_write), 32'd1);
    check("f1_pcn",   bus.Pc_next, 32'h104);
    check("f1_req0",  32'(bus.Mem_req), 32'd0);
    tick();
    check("f1_pcw_pulse", 32'(bus.Pc_write), 32'd0);
    check("f1_valid_hold", 32'(bus.Instr_valid), 32'd1);

    // Back-to-back: ack + start in the same HOLD cycle
    bus.Instr_ack   = 1'b1;
    bus.Fetch_start = 1'b1;
    bus.Pc_in       = 32'h0000_0104;
    tick();
    bus.Instr_ack   = 1'b0;
    bus.Fetch_start = 1'b0;
    check("b2b_req",   32'(bus.Mem_req), 32'd1);
    check("b2b_addr",  bus.Mem_addr, 32'h104);
    check("b2b_valid", 32'(bus.Instr_valid), 32'd0);
    bus.Mem_ready = 1'b1;
    bus.Mem_data  = 32'h0000_0013;
    tick();
    bus.Mem_ready = 1'b0;
    check("b2b_ipc", bus.Instr_pc, 32'h104);
    check("b2b_pcn", bus.Pc_next, 32'h108);
    bus.Instr_ack = 1'b1;
    tick();
    bus.Instr_ack = 1'b0;
    check("b2b_ack_valid", 32'(bus.Instr_valid), 32'd0);
    check("b2b_ack_busy",  32'(bus.Busy), 32'd0);

    // PC wrap
    bus.Pc_in       = 32'hFFFF_FFFC;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    bus.Mem_ready   = 1'b1;
    bus.Mem_data    = 32'hDEAD_BEEF;
    tick();
    bus.Mem_ready   = 1'b0;
    check("wrap_pcn", bus.Pc_next, 32'h0);
    check("wrap_pcw", 32'(bus.Pc_write), 32'd1);
    check("wrap_ipc", bus.Instr_pc, 32'hFFFF_FFFC);
    bus.Instr_ack = 1'b1;
    tick();
    bus.Instr_ack = 1'b0;

    // Flush coincident with Mem_ready
    bus.Pc_in       = 32'h0000_0200;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    bus.Mem_ready   = 1'b1;
    bus.Mem_data    = 32'h0000_0001;
    bus.Flush       = 1'b1;
    tick();
    bus.Mem_ready   = 1'b0;
    bus.Flush       = 1'b0;
    check("fl_valid", 32'(bus.Instr_valid), 32'd0);
    check("fl_pcw",   32'(bus.Pc_write), 32'd0);
    check("fl_busy",  32'(bus.Busy), 32'd0);
    check("fl_req",   32'(bus.Mem_req), 32'd0);
    check("fl_instr", bus.Instr_out, 32'hDEAD_BEEF);

    // Timeout after 4 REQ cycles without ready
    bus.Pc_in       = 32'h0000_0300;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    tick();
    tick();
    tick();
    check("to_req3", 32'(bus.Mem_req), 32'd1);
    check("to_err3", 32'(bus.Fetch_error), 32'd0);
    tick();
    check("to_err",  32'(bus.Fetch_error), 32'd1);
    check("to_req",  32'(bus.Mem_req), 32'd0);
    check("to_busy", 32'(bus.Busy), 32'd0);
    check("to_pcw",  32'(bus.Pc_write), 32'd0);
    tick();
    check("to_sticky", 32'(bus.Fetch_error), 32'd1);
    bus.Pc_in       = 32'h0000_0400;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    check("to_clr",   32'(bus.Fetch_error), 32'd0);
    check("mid_req",  32'(bus.Mem_req), 32'd1);

    // Async reset mid-REQ, checked before the next edge
    rst = 1'b1;
    #1;
    check("ar_req",   32'(bus.Mem_req), 32'd0);
    check("ar_busy",  32'(bus.Busy), 32'd0);
    check("ar_addr",  bus.Mem_addr, 32'h0);
    check("ar_instr", bus.Instr_out, 32'h0);
    check("ar_ipc",   bus.Instr_pc, 32'h0);
    tick();
    rst = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
    bus.Pc_in       = 32'h0000_0502;
    bus.Fetch_start = 1'b1;
    tick();
    bus.Fetch_start = 1'b0;
    check("mis_flag", 32'(bus.Misaligned), 32'd1);
    check("mis_req",  32'(bus.Mem_req), 32'd0);
    check("mis_busy", 32'(bus.Busy), 32'd0);
    tick();
    check("mis_pulse", 32'(bus.Misaligned), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
